kernel_launch_scheduler: RTL and testbench
==========================================

// Module: kernel_launch_scheduler
// PURPOSE
//  Multi-stream host launch front end for cta_dispatcher. Buffers kernel descriptors from
//  N_STREAMS independent host streams in per-stream FIFOs, picks one stream round-robin,
//  drives the dispatcher launch port and waits for that kernel to drain.
//  Reports per-kernel completion (stream, tag) back to the host. One kernel in flight at a time.
// PARAMETERS
//  N_STREAMS  4  number of host launch streams (>=2)
//  QDEPTH     2  descriptor FIFO entries per stream (>=1)
//  TAG_W      8  width of the per-stream launch sequence tag
// PORTS
//  clk                input   1                        clock
//  rst_n              input   1                        async reset, active-low
//  host_valid         input   [N_STREAMS]              stream i offers a descriptor
//  host_ready         output  [N_STREAMS]              stream i FIFO has space
//  host_desc          input   dice_kernel_desc_t[N_STREAMS]  descriptor per stream
//  host_tag           output  [N_STREAMS][TAG_W]       tag given to the next accepted descriptor of stream i
//  disp_launch_valid  output  1                        to cta_dispatcher launch_valid
//  disp_launch_ready  input   1                        from cta_dispatcher launch_ready (=idle)
//  disp_launch_desc   output  dice_kernel_desc_t       to cta_dispatcher launch_desc
//  done_valid         output  1                        a launched kernel has fully drained
//  done_ready         input   1                        host accepts the completion record
//  done_stream        output  $clog2(N_STREAMS)        stream of the completed kernel
//  done_tag           output  TAG_W                    tag of the completed kernel
//  busy               output  1                        FSM != IDLE or any FIFO non-empty
// BEHAVIOUR
//  Reset (async): all FIFOs empty, seq_q[i]=0, rr_ptr=0, FSM=IDLE. Outputs: host_ready='1, host_tag=0,
//   disp_launch_valid=0, done_valid=0, busy=0. disp_launch_desc, done_stream and done_tag are 0.
//  Enqueue: host_ready[i] = (count[i] < QDEPTH) and has no dequeue bypass. Accept on host_valid&host_ready.
//   Stores {host_desc[i], seq_q[i]}; seq_q[i] increments mod 2^TAG_W. host_tag[i]=seq_q[i].
//  FSM states IDLE, ISSUE, SETTLE, RUN, REPORT:
//   IDLE: if any FIFO non-empty, pick the first non-empty stream scanning from rr_ptr and latch its
//    index in cur_q. Go to ISSUE. rr_ptr <= winner+1 mod N_STREAMS. With no request, rr_ptr holds.
//   ISSUE: disp_launch_valid=1, disp_launch_desc = head of FIFO[cur_q], stable until handshake.
//    On valid&ready: pop FIFO[cur_q], latch cur_tag, go to SETTLE.
//   SETTLE: exactly 1 cycle. disp_launch_ready is ignored here to cover the dispatcher's registered
//    kernel_active update. Go to RUN.
//   RUN: when disp_launch_ready==1, the kernel has retired. Go to REPORT.
//   REPORT: done_valid=1, done_stream=cur_q, done_tag=cur_tag, held stable.
//    On done_ready, go to IDLE. No new launch is issued until the completion record is accepted.
//  Latency: descriptor accepted at edge t -> visible at t+1 -> IDLE decides -> disp_launch_valid high
//   during the cycle after edge t+2 (minimum, when FSM already IDLE).
//  Per-stream order is strict FIFO. Across streams, order is round-robin among non-empty streams.
//  Simultaneous enqueue to stream X and pop of stream X in the same cycle: count unchanged, both take effect.
//  Full FIFO: host_ready=0 even during a pop cycle. Space appears the cycle after the pop.
//  Tag wrap: 2^TAG_W-1 -> 0 with no stall.
//  Reset mid-operation returns everything to reset state and discards queued descriptors.
//   The dispatcher is reset by the same rst_n.
// TESTING
//  1 Single launch: stream 2 enqueues tag 0 at t; dispatcher ready. Expect disp_launch_valid at t+2.
//    Hold ready low 10 cycles, then high. Expect done_valid with done_stream=2, done_tag=0.
//  2 Round-robin: streams 0,1,3 each enqueue 1 descriptor in the same cycle.
//    Expect launch order 0,1,3 and rr_ptr=0 afterwards. Then streams 0 and 3 enqueue.
//    Expect order 0,3 (wrap past 3).
//  3 Backpressure/full: QDEPTH=2. Stream 1 pushes 3 back-to-back while the dispatcher stays busy.
//    Expect host_ready[1]=0 after 2 accepts. The third is accepted only the cycle after the first pop.
//    Tags are 0,1,2 in launch order.
//  4 Done stall: hold done_ready=0 for 5 cycles with stream 0 pending.
//    Expect done_valid stable, fields stable, and no disp_launch_valid until done_ready=1.
//  5 Tag wrap (TAG_W=2): 5 launches on stream 0. Expect done_tag sequence 0,1,2,3,0.
//  6 Async reset asserted during RUN with 2 queued: all outputs return to reset values immediately.
//    After release, busy=0 and no spurious launch.

Source files
------------

// File: rtl/kernel_launch_scheduler.sv
// Multi-stream kernel launch front end: per-stream descriptor FIFOs, a round-robin pick,
// one kernel in flight on the dispatcher, and a completion record returned to the host.
package dice_pkg;
  typedef struct packed {
    logic [15:0] entry_pc;
    logic [7:0]  num_ctas;
    logic [7:0]  kernel_arg;
  } dice_kernel_desc_t;
endpackage

module kernel_launch_scheduler
  import dice_pkg::*;
#(
  parameter int N_STREAMS = 4,
  parameter int QDEPTH    = 2,
  parameter int TAG_W     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_STREAMS-1:0]                host_valid,
  output logic [N_STREAMS-1:0]                host_ready,
  input  dice_kernel_desc_t [N_STREAMS-1:0]   host_desc,
  output logic [N_STREAMS-1:0][TAG_W-1:0]     host_tag,
  output logic                                disp_launch_valid,
  input  logic                                disp_launch_ready,
  output dice_kernel_desc_t                   disp_launch_desc,
  output logic                                done_valid,
  input  logic                                done_ready,
  output logic [$clog2(N_STREAMS)-1:0]        done_stream,
  output logic [TAG_W-1:0]                    done_tag,
  output logic                                busy
);

  localparam int SW = $clog2(N_STREAMS);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int DW = $bits(dice_kernel_desc_t);
  localparam int EW = DW + TAG_W;

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, RUN, REPORT} state_t;

  state_t                 state_reg;
  logic [SW-1:0]          rr_ptr_reg;
  logic [SW-1:0]          cur_q_reg;
  logic [TAG_W-1:0]       cur_tag_reg;

  logic [N_STREAMS-1:0]   push;
  logic [N_STREAMS-1:0]   pop;
  logic [N_STREAMS-1:0]   nonempty;
  logic [N_STREAMS-1:0]   avail;
  logic [N_STREAMS-1:0]   req;
  dice_kernel_desc_t      head_desc [N_STREAMS];
  logic [TAG_W-1:0]       head_tag  [N_STREAMS];

  logic                   found;
  logic [SW-1:0]          winner;
  logic [SW-1:0]          rr_next;
  logic [SW-1:0]          scan_idx;
  int                     scan_sum;

  genvar gi;
  generate
    for (gi = 0; gi < N_STREAMS; gi++) begin : g_stream
      logic [CW-1:0]    count_reg;
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [TAG_W-1:0] seq_reg;
      logic             avail_reg;
      logic [EW-1:0]    mem [QDEPTH];
      logic [PW-1:0]    wr_ptr_next;
      logic [PW-1:0]    rd_ptr_next;

      // A full FIFO refuses a push even while it is being popped.
      assign host_ready[gi]  = (count_reg < CW'(QDEPTH));
      assign host_tag[gi]    = seq_reg;
      assign push[gi]        = host_valid[gi] & host_ready[gi];
      assign pop[gi]         = (state_reg == ISSUE) && disp_launch_ready && (cur_q_reg == SW'(gi));
      assign nonempty[gi]    = (count_reg != '0);
      assign avail[gi]       = avail_reg;
      assign head_desc[gi]   = dice_kernel_desc_t'(mem[rd_ptr_reg][EW-1:TAG_W]);
      assign head_tag[gi]    = mem[rd_ptr_reg][TAG_W-1:0];
      assign wr_ptr_next     = (wr_ptr_reg == PW'(QDEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      assign rd_ptr_next     = (rd_ptr_reg == PW'(QDEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);

      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_ptr_reg] <= {host_desc[gi], seq_reg};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg  <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          seq_reg    <= '0;
          avail_reg  <= 1'b0;
        end else begin
          if (push[gi]) begin
            wr_ptr_reg <= wr_ptr_next;
            seq_reg    <= seq_reg + TAG_W'(1);
          end
          if (pop[gi]) rd_ptr_reg <= rd_ptr_next;
          if (push[gi] && !pop[gi])
            count_reg <= count_reg + CW'(1);
          else if (!push[gi] && pop[gi])
            count_reg <= count_reg - CW'(1);
          // Lags occupancy by one cycle so a new entry is seen by the arbiter one cycle later.
          avail_reg <= nonempty[gi];
        end
      end
    end
  endgenerate

  assign req = avail & nonempty;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = 0;
    scan_idx = '0;
    for (int k = 0; k < N_STREAMS; k++) begin
      scan_sum = int'(rr_ptr_reg) + k;
      if (scan_sum >= N_STREAMS) scan_sum = scan_sum - N_STREAMS;
      scan_idx = SW'(scan_sum);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign rr_next = (winner == SW'(N_STREAMS - 1)) ? '0 : winner + SW'(1);
  assign busy    = (state_reg != IDLE) || (|nonempty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      rr_ptr_reg        <= '0;
      cur_q_reg         <= '0;
      cur_tag_reg       <= '0;
      disp_launch_valid <= 1'b0;
      disp_launch_desc  <= '0;
      done_valid        <= 1'b0;
      done_stream       <= '0;
      done_tag          <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            cur_q_reg         <= winner;
            rr_ptr_reg        <= rr_next;
            disp_launch_desc  <= head_desc[winner];
            disp_launch_valid <= 1'b1;
            state_reg         <= ISSUE;
          end
        end
        ISSUE: begin
          if (disp_launch_ready) begin
            disp_launch_valid <= 1'b0;
            cur_tag_reg       <= head_tag[cur_q_reg];
            state_reg         <= SETTLE;
          end
        end
        // The dispatcher's ready still reads idle for one cycle after it accepts.
        SETTLE: state_reg <= RUN;
        RUN: begin
          if (disp_launch_ready) begin
            done_valid  <= 1'b1;
            done_stream <= cur_q_reg;
            done_tag    <= cur_tag_reg;
            state_reg   <= REPORT;
          end
        end
        REPORT: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_launch_scheduler.sv
// Directed bench for kernel_launch_scheduler with a hand-driven dispatcher and host.
// TAG_W is 2 so tag wrap is reachable in a few launches.
module tb_kernel_launch_scheduler;
  import dice_pkg::*;

  localparam int N  = 4;
  localparam int Q  = 2;
  localparam int TW = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N-1:0]            host_valid = '0;
  logic [N-1:0]            host_ready;
  dice_kernel_desc_t [N-1:0] host_desc = '0;
  logic [N-1:0][TW-1:0]    host_tag;
  logic                    disp_launch_valid;
  logic                    disp_launch_ready = 1'b1;
  dice_kernel_desc_t       disp_launch_desc;
  logic                    done_valid;
  logic                    done_ready = 1'b1;
  logic [1:0]              done_stream;
  logic [TW-1:0]           done_tag;
  logic                    busy;

  int tests = 0;
  int fails = 0;

  kernel_launch_scheduler #(.N_STREAMS(N), .QDEPTH(Q), .TAG_W(TW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host_valid        (host_valid),
    .host_ready        (host_ready),
    .host_desc         (host_desc),
    .host_tag          (host_tag),
    .disp_launch_valid (disp_launch_valid),
    .disp_launch_ready (disp_launch_ready),
    .disp_launch_desc  (disp_launch_desc),
    .done_valid        (done_valid),
    .done_ready        (done_ready),
    .done_stream       (done_stream),
    .done_tag          (done_tag),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic dice_kernel_desc_t mk(input int s, input int n);
    dice_kernel_desc_t d;
    d.entry_pc   = 16'h1000 + 16'(s * 256 + n);
    d.num_ctas   = 8'(n + 1);
    d.kernel_arg = 8'(s);
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    host_valid = '0;
    disp_launch_ready = 1'b1;
    done_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_one(input int s, input int n);
    int i;
    host_valid[s] = 1'b1;
    host_desc[s]  = mk(s, n);
    for (i = 0; i < 40 && !host_ready[s]; i++) tick();
    chk("push_ready", 32'(host_ready[s]), 32'd1);
    tick();
    host_valid[s] = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40 && !disp_launch_valid; i++) tick();
    chk({name, "_launch"}, 32'(disp_launch_valid), 32'd1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && !done_valid; i++) tick();
    chk({name, "_done"}, 32'(done_valid), 32'd1);
  endtask

  task automatic expect_launch(input int s, input int n);
    wait_valid("exp");
    chk("launch_desc", 32'(disp_launch_desc), 32'(mk(s, n)));
    $display("[TB] launch desc=%h", disp_launch_desc);
    disp_launch_ready = 1'b1;
    tick();
  endtask

  task automatic expect_done(input int s, input int t);
    wait_done("exp");
    chk("done_stream", 32'(done_stream), 32'(s));
    chk("done_tag", 32'(done_tag), 32'(t));
    $display("[TB] done stream=%0d tag=%0d", done_stream, done_tag);
    done_ready = 1'b1;
    tick();
    chk("done_drop", 32'(done_valid), 32'd0);
  endtask

  task automatic run_one(input int s, input int n, input int t);
    expect_launch(s, n);
    expect_done(s, t);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_host_ready", 32'(host_ready), 32'hF);
    chk("rst_host_tag", 32'(host_tag), 32'd0);
    chk("rst_launch_valid", 32'(disp_launch_valid), 32'd0);
    chk("rst_launch_desc", 32'(disp_launch_desc), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_fields", 32'({done_stream, done_tag}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 1: single launch on stream 2 with exact latency
    host_valid[2] = 1'b1;
    host_desc[2]  = mk(2, 0);
    tick();
    host_valid[2] = 1'b0;
    chk("t1_tag_inc", 32'(host_tag[2]), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_t", 32'(disp_launch_valid), 32'd0);
    tick();
    chk("t1_valid_t1", 32'(disp_launch_valid), 32'd0);
    tick();
    chk("t1_valid_t2", 32'(disp_launch_valid), 32'd1);
    chk("t1_desc", 32'(disp_launch_desc), 32'(mk(2, 0)));
    tick();
    disp_launch_ready = 1'b0;
    chk("t1_valid_drop", 32'(disp_launch_valid), 32'd0);
    repeat (11) tick();
    chk("t1_no_early_done", 32'(done_valid), 32'd0);
    disp_launch_ready = 1'b1;
    tick();
    chk("t1_done_valid", 32'(done_valid), 32'd1);
    chk("t1_done_stream", 32'(done_stream), 32'd2);
    chk("t1_done_tag", 32'(done_tag), 32'd0);
    tick();
    chk("t1_done_drop", 32'(done_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: round-robin across streams 0,1,3 then 0,3
    do_reset();
    host_valid   = 4'b1011;
    host_desc[0] = mk(0, 0);
    host_desc[1] = mk(1, 0);
    host_desc[3] = mk(3, 0);
    tick();
    host_valid = '0;
    run_one(0, 0, 0);
    run_one(1, 0, 0);
    run_one(3, 0, 0);
    chk("t2_rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
    host_valid   = 4'b1001;
    host_desc[0] = mk(0, 1);
    host_desc[3] = mk(3, 1);
    tick();
    host_valid = '0;
    run_one(0, 1, 1);
    run_one(3, 1, 1);

    // 3: stream 1 fills its FIFO while the dispatcher is busy
    do_reset();
    disp_launch_ready = 1'b0;
    host_valid[1] = 1'b1;
    host_desc[1]  = mk(1, 0);
    tick();
    chk("t3_ready_after1", 32'(host_ready[1]), 32'd1);
    host_desc[1] = mk(1, 1);
    tick();
    chk("t3_ready_full", 32'(host_ready[1]), 32'd0);
    chk("t3_tag_full", 32'(host_tag[1]), 32'd2);
    host_desc[1] = mk(1, 2);
    tick();
    tick();
    chk("t3_issue_valid", 32'(disp_launch_valid), 32'd1);
    chk("t3_issue_desc", 32'(disp_launch_desc), 32'(mk(1, 0)));
    chk("t3_still_full", 32'(host_ready[1]), 32'd0);
    disp_launch_ready = 1'b1;
    tick();
    chk("t3_space_after_pop", 32'(host_ready[1]), 32'd1);
    chk("t3_no_push_on_pop", 32'(host_tag[1]), 32'd2);
    disp_launch_ready = 1'b0;
    tick();
    host_valid[1] = 1'b0;
    chk("t3_third_accepted", 32'(host_tag[1]), 32'd3);
    chk("t3_full_again", 32'(host_ready[1]), 32'd0);
    disp_launch_ready = 1'b1;
    expect_done(1, 0);
    run_one(1, 1, 1);
    run_one(1, 2, 2);

    // 4: completion record stalls the next launch
    do_reset();
    done_ready = 1'b0;
    push_one(0, 0);
    push_one(0, 1);
    expect_launch(0, 0);
    wait_done("t4");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 32'(done_valid), 32'd1);
      chk("t4_hold_stream", 32'(done_stream), 32'd0);
      chk("t4_hold_tag", 32'(done_tag), 32'd0);
      chk("t4_no_launch", 32'(disp_launch_valid), 32'd0);
    end
    done_ready = 1'b1;
    tick();
    chk("t4_release", 32'(done_valid), 32'd0);
    run_one(0, 1, 1);

    // 5: tag wrap on stream 0
    do_reset();
    push_one(0, 0);
    push_one(0, 1);
    chk("t5_tag2", 32'(host_tag[0]), 32'd2);
    run_one(0, 0, 0);
    run_one(0, 1, 1);
    push_one(0, 2);
    push_one(0, 3);
    chk("t5_tag_wrap", 32'(host_tag[0]), 32'd0);
    run_one(0, 2, 2);
    run_one(0, 3, 3);
    push_one(0, 4);
    run_one(0, 4, 0);

    // 6: async reset during RUN with two descriptors queued
    do_reset();
    host_valid   = 4'b0111;
    host_desc[0] = mk(0, 0);
    host_desc[1] = mk(1, 0);
    host_desc[2] = mk(2, 0);
    tick();
    host_valid = '0;
    wait_valid("t6");
    chk("t6_desc", 32'(disp_launch_desc), 32'(mk(0, 0)));
    tick();
    disp_launch_ready = 1'b0;
    tick();
    tick();
    chk("t6_busy_run", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(host_ready), 32'hF);
    chk("t6_rst_tag", 32'(host_tag), 32'd0);
    chk("t6_rst_valid", 32'(disp_launch_valid), 32'd0);
    chk("t6_rst_desc", 32'(disp_launch_desc), 32'd0);
    chk("t6_rst_done", 32'({done_valid, done_stream, done_tag}), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    disp_launch_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_spurious", 32'(disp_launch_valid), 32'd0);
      chk("t6_idle_busy", 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
